// File: rtl/hough_pkg.sv
// Shared types and helpers for the Hough peak-selection path.
package hough_pkg;

  localparam int unsigned DEF_ANGLE_RANGE  = 180;
  localparam int unsigned DEF_RHO_BINS     = 900;
  localparam int unsigned DEF_VOTE_WIDTH   = 16;
  localparam int unsigned DEF_RADIUS_WIDTH = 16;
  localparam int unsigned DEF_THRESHOLD    = 100;

  localparam int unsigned ANGLE_W     = $clog2(DEF_ANGLE_RANGE);
  localparam int unsigned PEAK_WORD_W = 1 + ANGLE_W + DEF_RADIUS_WIDTH;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    EMIT0 = 2'd1,
    EMIT1 = 2'd2
  } state_t;

  // Running-best entry; fields sized for the widest supported configuration.
  typedef struct packed {
    logic                        valid;
    logic [DEF_VOTE_WIDTH-1:0]   vote;
    logic [ANGLE_W-1:0]          angle;
    logic [DEF_RADIUS_WIDTH-1:0] radius;
  } peak_t;

  // {valid, angle, radius} word as unpacked by the highlight stage; invalid -> all zero.
  function automatic logic [PEAK_WORD_W-1:0] pack_peak(input peak_t p);
    return p.valid ? {1'b1, p.angle, p.radius} : '0;
  endfunction

endpackage

// File: rtl/hough_peak_select_peak_insert2.sv
// Two-entry sorted insert of a candidate peak; ties keep the incumbent.
module peak_insert2
  import hough_pkg::*;
(
  input  logic  i_en,
  input  peak_t i_cand,
  input  peak_t i_best0,
  input  peak_t i_best1,
  output peak_t o_best0_c,
  output peak_t o_best1_c
);

  // Place the candidate at rank 0 or 1 when it strictly beats that slot
  always_comb begin
    o_best0_c = i_best0;
    o_best1_c = i_best1;
    if (i_en && i_cand.valid) begin
      if (!i_best0.valid || (i_cand.vote > i_best0.vote)) begin
        o_best1_c = i_best0;
        o_best0_c = i_cand;
      end else if (!i_best1.valid || (i_cand.vote > i_best1.vote)) begin
        o_best1_c = i_cand;
      end
    end
  end

endmodule

// File: rtl/hough_peak_select.sv
// Streams one frame of Hough votes and emits the two strongest (angle, radius) peaks.
module hough_peak_select #(
  parameter int unsigned ANGLE_RANGE  = hough_pkg::DEF_ANGLE_RANGE,
  parameter int unsigned RHO_BINS     = hough_pkg::DEF_RHO_BINS,
  parameter int unsigned VOTE_WIDTH   = hough_pkg::DEF_VOTE_WIDTH,
  parameter int unsigned RADIUS_WIDTH = hough_pkg::DEF_RADIUS_WIDTH,
  parameter int unsigned THRESHOLD    = hough_pkg::DEF_THRESHOLD
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     in_empty,
  output logic                                     in_rd_en,
  input  logic [VOTE_WIDTH-1:0]                    in_dout,
  input  logic                                     out_full,
  output logic                                     out_wr_en,
  output logic [$clog2(ANGLE_RANGE)+RADIUS_WIDTH:0] out_din
);
  import hough_pkg::*;

  localparam int unsigned ANG_W = $clog2(ANGLE_RANGE);
  localparam int unsigned RHO_W = $clog2(RHO_BINS);
  localparam int unsigned OUT_W = 1 + ANG_W + RADIUS_WIDTH;

  state_t           r_state, w_state_nxt;
  logic [ANG_W-1:0] r_ang_cnt, w_ang_cnt_nxt;
  logic [RHO_W-1:0] r_rho_cnt, w_rho_cnt_nxt;
  peak_t            r_best0, r_best1, w_best0_nxt, w_best1_nxt;
  peak_t            w_cand, w_ins0, w_ins1;
  logic             w_consume, w_rho_last, w_last_bin;
  logic [OUT_W-1:0] w_word0, w_word1;

  // Output word at this instance's angle/radius widths; invalid entries read as zero
  function automatic logic [OUT_W-1:0] pack_out(input peak_t p);
    return p.valid ? {1'b1, ANG_W'(p.angle), RADIUS_WIDTH'(p.radius)} : '0;
  endfunction

  // Candidate built from the current vote and scan position
  always_comb begin
    w_cand        = '0;
    w_cand.valid  = (in_dout >= VOTE_WIDTH'(THRESHOLD));
    w_cand.vote   = DEF_VOTE_WIDTH'(in_dout);
    w_cand.angle  = ANGLE_W'(r_ang_cnt);
    w_cand.radius = DEF_RADIUS_WIDTH'(RADIUS_WIDTH'(r_rho_cnt));
  end

  assign w_consume  = (r_state == SCAN) && !in_empty;
  assign w_rho_last = (r_rho_cnt == RHO_W'(RHO_BINS - 1));
  assign w_last_bin = w_rho_last && (r_ang_cnt == ANG_W'(ANGLE_RANGE - 1));
  assign w_word0    = pack_out(r_best0);
  assign w_word1    = pack_out(r_best1);

  peak_insert2 u_insert (
    .i_en      (w_consume),
    .i_cand    (w_cand),
    .i_best0   (r_best0),
    .i_best1   (r_best1),
    .o_best0_c (w_ins0),
    .o_best1_c (w_ins1)
  );

  // State and scan registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= SCAN;
      r_ang_cnt <= '0;
      r_rho_cnt <= '0;
      r_best0   <= '0;
      r_best1   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ang_cnt <= w_ang_cnt_nxt;
      r_rho_cnt <= w_rho_cnt_nxt;
      r_best0   <= w_best0_nxt;
      r_best1   <= w_best1_nxt;
    end
  end

  // Next-state, FIFO handshakes and output word selection (data decoded from registers only)
  always_comb begin
    w_state_nxt   = r_state;
    w_ang_cnt_nxt = r_ang_cnt;
    w_rho_cnt_nxt = r_rho_cnt;
    w_best0_nxt   = r_best0;
    w_best1_nxt   = r_best1;
    in_rd_en      = 1'b0;
    out_wr_en     = 1'b0;
    out_din       = '0;
    case (r_state)
      SCAN: begin
        in_rd_en = !in_empty;
        if (!in_empty) begin
          w_best0_nxt = w_ins0;
          w_best1_nxt = w_ins1;
          if (w_rho_last) begin
            w_rho_cnt_nxt = '0;
            w_ang_cnt_nxt = r_ang_cnt + ANG_W'(1);
          end else begin
            w_rho_cnt_nxt = r_rho_cnt + RHO_W'(1);
          end
          if (w_last_bin) begin
            w_state_nxt = EMIT0;
          end
        end
      end
      EMIT0: begin
        out_wr_en = !out_full;
        out_din   = w_word0;
        if (!out_full) begin
          w_state_nxt = EMIT1;
        end
      end
      EMIT1: begin
        out_wr_en = !out_full;
        out_din   = w_word1;
        if (!out_full) begin
          w_state_nxt   = SCAN;
          w_best0_nxt   = '0;
          w_best1_nxt   = '0;
          w_ang_cnt_nxt = '0;
          w_rho_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = SCAN;
      end
    endcase
  end

endmodule

// File: tb/tb_hough_peak_select.sv
// Directed + randomized frames checked against a top-2 argmax reference model.
module tb_hough_peak_select;

  localparam int NA  = 4;
  localparam int NR  = 4;
  localparam int NV  = NA * NR;
  localparam int THR = 5;

  logic        clock;
  logic        reset;
  logic        in_empty;
  logic        in_rd_en;
  logic [15:0] in_dout;
  logic        out_full;
  logic        out_wr_en;
  logic [18:0] out_din;

  int checks;
  int errors;
  int unsigned f[NV];

  hough_peak_select #(
    .ANGLE_RANGE (NA),
    .RHO_BINS    (NR),
    .VOTE_WIDTH  (16),
    .RADIUS_WIDTH(16),
    .THRESHOLD   (THR)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_empty (in_empty),
    .in_rd_en (in_rd_en),
    .in_dout  (in_dout),
    .out_full (out_full),
    .out_wr_en(out_wr_en),
    .out_din  (out_din)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] word_of(input int b);
    logic [18:0] w;
    if (b < 0) w = '0;
    else       w = {1'b1, 2'(b / NR), 16'(b % NR)};
    return w;
  endfunction

  // Reference: strongest qualifying bin (earliest on ties), then strongest of the remainder
  task automatic model(input int unsigned v[NV], output logic [18:0] e0, output logic [18:0] e1);
    int b0;
    int b1;
    b0 = -1;
    b1 = -1;
    for (int i = 0; i < NV; i++)
      if (v[i] >= THR && (b0 < 0 || v[i] > v[b0])) b0 = i;
    for (int i = 0; i < NV; i++)
      if (i != b0 && v[i] >= THR && (b1 < 0 || v[i] > v[b1])) b1 = i;
    e0 = word_of(b0);
    e1 = word_of(b1);
  endtask

  task automatic clear_frame();
    for (int i = 0; i < NV; i++) f[i] = 0;
  endtask

  // Feed one frame through an FWFT source, capture writes, check handshakes and timing
  task automatic run_frame(input int unsigned v[NV], input bit gappy, input int full_hold,
                           input string name);
    int idx;
    int writes;
    int cyc;
    int last_pop;
    int full_left;
    logic [18:0] got0;
    logic [18:0] got1;
    logic [18:0] e0;
    logic [18:0] e1;
    idx = 0; writes = 0; cyc = 0; last_pop = -1; full_left = full_hold;
    got0 = '0; got1 = '0;
    model(v, e0, e1);
    while (writes < 2 && cyc < 400) begin
      @(negedge clock);
      if (idx < NV) begin
        in_empty = gappy && (cyc % 2 == 1);
        in_dout  = in_empty ? 16'($urandom) : 16'(v[idx]);
        out_full = 1'b0;
      end else begin
        in_empty = 1'b0;
        in_dout  = 16'($urandom);
        out_full = (full_left > 0);
      end
      #1;
      if (idx < NV) begin
        chk({name, "/rd_en_scan"}, 32'(in_rd_en), 32'(!in_empty));
        chk({name, "/wr_en_scan"}, 32'(out_wr_en), 32'd0);
      end else begin
        chk({name, "/rd_en_emit"}, 32'(in_rd_en), 32'd0);
      end
      if (out_full) chk({name, "/wr_en_full"}, 32'(out_wr_en), 32'd0);
      if (idx < NV && in_rd_en) begin
        idx++;
        if (idx == NV) last_pop = cyc;
      end
      if (out_wr_en) begin
        if (writes == 0) begin
          chk({name, "/latency"}, 32'(cyc), 32'(last_pop + 1 + full_hold));
          got0 = out_din;
        end else begin
          got1 = out_din;
        end
        writes++;
      end
      if (idx == NV && out_full) full_left--;
      cyc++;
    end
    chk({name, "/writes"}, 32'(writes), 32'd2);
    chk({name, "/word0"}, 32'(got0), 32'(e0));
    chk({name, "/word1"}, 32'(got1), 32'(e1));
    @(negedge clock);
    in_empty = 1'b1;
    out_full = 1'b0;
    #1;
    chk({name, "/no_extra_write"}, 32'(out_wr_en), 32'd0);
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clock);
    reset    = 1'b1;
    in_empty = 1'b1;
    out_full = 1'b0;
    #1;
    chk({name, "/rst_rd_en"}, 32'(in_rd_en), 32'd0);
    chk({name, "/rst_wr_en"}, 32'(out_wr_en), 32'd0);
    chk({name, "/rst_dout"}, 32'(out_din), 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    in_empty = 1'b1;
    in_dout  = '0;
    out_full = 1'b0;
    repeat (2) @(negedge clock);
    pulse_reset("init");

    // 1: two peaks in different angles
    clear_frame();
    f[2*NR+3] = 9;
    f[0*NR+1] = 7;
    run_frame(f, 1'b0, 0, "s1");

    // 2: equal votes, earlier bin ranks first
    clear_frame();
    f[1*NR+0] = 6;
    f[3*NR+2] = 6;
    run_frame(f, 1'b0, 0, "s2");

    // 3: everything below threshold
    for (int i = 0; i < NV; i++) f[i] = 4;
    run_frame(f, 1'b0, 0, "s3");

    // 4: gappy source and downstream backpressure
    clear_frame();
    f[2*NR+3] = 9;
    f[0*NR+1] = 7;
    run_frame(f, 1'b1, 5, "s4");

    // 5: reset in the middle of a frame full of strong votes
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      in_empty = 1'b0;
      in_dout  = 16'(50 + k);
      #1;
      chk("s5/partial_rd_en", 32'(in_rd_en), 32'd1);
    end
    pulse_reset("s5");
    clear_frame();
    f[2*NR+3] = 9;
    f[0*NR+1] = 7;
    run_frame(f, 1'b0, 0, "s5");

    // 6: random frame followed by a single-peak frame
    for (int i = 0; i < NV; i++) f[i] = $urandom_range(0, 12);
    run_frame(f, 1'b0, 0, "s6a");
    clear_frame();
    f[3*NR+3] = 8;
    run_frame(f, 1'b0, 0, "s6b");

    // Extra randomized frames with random source gaps and backpressure
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NV; i++) f[i] = $urandom_range(0, 12);
      run_frame(f, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
